// File: rtl/pc_branch_unit.sv
// Program counter with fetch handshake and PC-relative branch / absolute jump resolution.
// Optional taken-branch counter output enabled by defining PC_BRANCH_COUNT_EN.
module pc_branch_unit #(
  parameter int unsigned       PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] offset,
  input  logic            br_req,
  input  logic            br_cond,
  input  logic            jmp_req,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            halt,
  input  logic            fetch_ack,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic            br_taken,
  output logic            halted
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [7:0]      br_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic            br_taken_n;
  logic            fetch_req_n;
  logic            halted_n;

`ifdef PC_BRANCH_COUNT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] br_count_n;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      fetch_req <= 1'b0;
      br_taken  <= 1'b0;
      halted    <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
      br_count  <= '0;
`endif
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      fetch_req <= fetch_req_n;
      br_taken  <= br_taken_n;
      halted    <= halted_n;
`ifdef PC_BRANCH_COUNT_EN
      br_count  <= br_count_n;
`endif
    end
  end

  // Next-state and next-PC selection; jump beats branch, branch is relative to current pc
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    br_taken_n = 1'b0;
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: if (fetch_ack) state_n = EXEC;
      EXEC: begin
        if (jmp_req) begin
          pc_n       = jmp_addr;
          br_taken_n = 1'b1;
        end else if (br_req && br_cond) begin
          pc_n       = pc + offset;
          br_taken_n = 1'b1;
        end else begin
          pc_n = pc + PC_W'(1);
        end
        state_n = halt ? HALT : FETCH;
      end
      HALT:  if (!halt) state_n = FETCH;
      default: state_n = IDLE;
    endcase
    fetch_req_n = (state_n == FETCH);
    halted_n    = (state_n == HALT);
  end

`ifdef PC_BRANCH_COUNT_EN
  // Saturating count of taken branches and jumps
  always_comb begin
    br_count_n = br_count;
    if (br_taken_n && (br_count != {CNT_W{1'b1}}))
      br_count_n = br_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: driver pushes expected EXEC results computed from a
// behavioural PC model; an independent monitor pops and compares after each EXEC edge.
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] offset;
  logic       br_req, br_cond, jmp_req, halt, fetch_ack;
  logic [7:0] jmp_addr;
  logic [7:0] pc;
  logic       fetch_req, br_taken, halted;
`ifdef PC_BRANCH_COUNT_EN
  logic [7:0] br_count;
`endif

  pc_branch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .offset   (offset),
    .br_req   (br_req),
    .br_cond  (br_cond),
    .jmp_req  (jmp_req),
    .jmp_addr (jmp_addr),
    .halt     (halt),
    .fetch_ack(fetch_ack),
    .pc       (pc),
    .fetch_req(fetch_req),
    .br_taken (br_taken),
    .halted   (halted)
`ifdef PC_BRANCH_COUNT_EN
    ,
    .br_count (br_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int bt;
    int h;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_pc = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: track handshake edges, then compare once per completed EXEC edge
  logic ack_d = 1'b0, exec_d = 1'b0, bt_chk = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      ack_d  <= 1'b0;
      exec_d <= 1'b0;
    end else begin
      ack_d  <= fetch_req & fetch_ack;
      exec_d <= ack_d;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bt_chk && rst_n) check("br_taken_pulse_width", int'(br_taken), 0);
    bt_chk = 1'b0;
    if (exec_d && rst_n) begin
      if (q.size() == 0) begin
        check("queue_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        check("exec_pc", int'(pc), e.pc);
        check("exec_br_taken", int'(br_taken), e.bt);
        check("exec_halted", int'(halted), e.h);
        check("exec_fetch_req", int'(fetch_req), e.h ? 0 : 1);
`ifdef PC_BRANCH_COUNT_EN
        check("br_count", int'(br_count), e.cnt);
`endif
        bt_chk = 1'b1;
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!fetch_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_wait_timeout", int'(fetch_req), 1);
    check("fetch_pc", int'(pc), model_pc);
  endtask

  // One instruction: optional stall, ack with EXEC inputs, optional halt for hcyc cycles
  task automatic run_instr(input int stall, input logic b, input logic c, input logic [7:0] off,
                           input logic j, input logic [7:0] ja, input logic h, input int hcyc);
    exp_t e;
    wait_fetch();
    fetch_ack = 1'b0;
    repeat (stall) @(negedge clk);
    br_req = b; br_cond = c; offset = off; jmp_req = j; jmp_addr = ja; halt = h;
    fetch_ack = 1'b1;
    if (j) begin
      e.pc = int'(ja); e.bt = 1;
    end else if (b && c) begin
      e.pc = (model_pc + int'(off)) % 256; e.bt = 1;
    end else begin
      e.pc = (model_pc + 1) % 256; e.bt = 0;
    end
    if (e.bt == 1 && model_cnt < 255) model_cnt++;
    e.h = h ? 1 : 0;
    e.cnt = model_cnt;
    model_pc = e.pc;
    q.push_back(e);
    @(negedge clk);
    check("exec_fetch_req_low", int'(fetch_req), 0);
    fetch_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    fetch_ack = 1'b0;
    br_req = 1'($urandom); br_cond = 1'($urandom); jmp_req = 1'($urandom);
    offset = 8'($urandom); jmp_addr = 8'($urandom);
    if (h) begin
      for (int k = 1; k < hcyc; k++) begin
        fetch_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("halt_halted", int'(halted), 1);
        check("halt_pc_hold", int'(pc), model_pc);
      end
      fetch_ack = 1'b0;
    end
    halt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; offset = '0; br_req = 0; br_cond = 0; jmp_req = 0;
    jmp_addr = '0; halt = 0; fetch_ack = 0;
    repeat (2) @(negedge clk);
    check("reset_pc", int'(pc), 0);
    check("reset_fetch_req", int'(fetch_req), 0);
    check("reset_br_taken", int'(br_taken), 0);
    check("reset_halted", int'(halted), 0);
    rst_n = 1'b1;

    // Sequential
    for (int i = 0; i < 4; i++) run_instr(i % 2, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    // Backward branch taken / not taken
    run_instr(0, 0, 0, 8'h00, 1, 8'h05, 0, 0);
    run_instr(0, 1, 1, 8'hFD, 0, 8'h00, 0, 0);
    run_instr(0, 0, 0, 8'h00, 1, 8'h05, 0, 0);
    run_instr(0, 1, 0, 8'hFD, 0, 8'h00, 0, 0);
    run_instr(0, 0, 1, 8'h10, 0, 8'h00, 0, 0);
    // Wrap
    run_instr(0, 0, 0, 8'h00, 1, 8'hFE, 0, 0);
    run_instr(0, 1, 1, 8'h05, 0, 8'h00, 0, 0);
    run_instr(0, 0, 0, 8'h00, 1, 8'hFF, 0, 0);
    run_instr(0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    // Priority with halt
    run_instr(0, 0, 0, 8'h00, 1, 8'h10, 0, 0);
    run_instr(0, 1, 1, 8'h02, 1, 8'h40, 1, 3);
    // Self-loop and counter saturation
    for (int i = 0; i < 300; i++) run_instr(0, 1, 1, 8'h00, 0, 8'h00, 0, 0);
    // Random instruction mix
    for (int i = 0; i < 200; i++)
      run_instr($urandom_range(0, 3), 1'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 5) == 0), 8'($urandom),
                ($urandom_range(0, 7) == 0), $urandom_range(1, 4));

    // Stall then reset mid-handshake
    run_instr(0, 0, 0, 8'h00, 1, 8'h07, 0, 0);
    wait_fetch();
    fetch_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_fetch_req", int'(fetch_req), 1);
      check("stall_pc", int'(pc), 7);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_pc", int'(pc), 0);
    check("midreset_fetch_req", int'(fetch_req), 0);
    check("midreset_halted", int'(halted), 0);
    rst_n = 1'b1;
    model_pc = 0;
    model_cnt = 0;
    run_instr(0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    run_instr(0, 1, 1, 8'h03, 0, 8'h00, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
